// File: rtl/add_pkg.sv
// Shared width constants for the 4-bit ripple-carry adder.
package add_pkg;
  localparam int OP_W  = 4;
  localparam int RES_W = 5;
endpackage

// File: rtl/add_full_adder.sv
// One-bit full adder cell used as a ripple-carry stage.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/add.sv
// 4-bit ripple-carry adder with combinational sum and a registered copy.
module add
  import add_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  num1,
  input  logic [OP_W-1:0]  num2,
  output logic [OP_W-1:0]  out,
  output logic             cout,
  output logic [RES_W-1:0] sum_q
);

  logic [RES_W-1:0] carry;
  logic [RES_W-1:0] sum_d;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < OP_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (num1[i]),
      .b    (num2[i]),
      .cin  (carry[i]),
      .s    (out[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[OP_W];

  always_comb begin
    sum_d = {cout, out};
    if (rst) sum_d = '0;
  end

  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

endmodule

// File: tb/tb_add.sv
// Scoreboard bench for the ripple-carry adder and its result register.
module tb_add;

  logic       clk;
  logic       rst;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] out;
  logic       cout;
  logic [4:0] sum_q;

  logic       clk_en = 1'b0;
  int         n_vec  = 0;
  int         n_err  = 0;
  logic [4:0] sb_q[$];

  add dut (
    .clk   (clk),
    .rst   (rst),
    .num1  (num1),
    .num2  (num2),
    .out   (out),
    .cout  (cout),
    .sum_q (sum_q)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [4:0] got,
                     input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] e;
    num1 = a;
    num2 = b;
    e = {1'b0, a} + {1'b0, b};
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] got);
    logic [4:0] e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %b, expected a queued value", tag, got);
    end else begin
      e = sb_q.pop_front();
      chk(tag, got, e);
    end
  endtask

  logic [3:0] da[4] = '{4'h0, 4'h0, 4'hF, 4'h8};
  logic [3:0] db[4] = '{4'h0, 4'h1, 4'h1, 4'h8};

  initial begin
    // clk and rst are still X here
    drive(4'b0101, 4'b0011);
    #1;
    pop_chk("unclocked", {cout, out});
    chk("unclocked_lit", {cout, out}, 5'b01000);

    for (int k = 0; k < 4; k++) begin
      drive(da[k], db[k]);
      #1;
      pop_chk("directed", {cout, out});
    end
    drive(4'hF, 4'hF);
    #1;
    chk("ovf_max", {cout, out}, 5'b11110);
    void'(sb_q.pop_front());

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        drive(4'(i), 4'(j));
        #1;
        pop_chk("exhaustive", {cout, out});
      end
    end

    clk = 1'b0;
    clk_en = 1'b1;
    rst = 1'b1;
    num1 = 4'h7;
    num2 = 4'h6;
    @(posedge clk); #1;
    chk("rst_q", sum_q, 5'b00000);
    chk("rst_comb", {cout, out}, 5'b01101);

    rst = 1'b0;
    drive(4'hF, 4'hF);
    @(posedge clk); #1;
    pop_chk("reg_ff", sum_q);

    for (int k = 0; k < 8; k++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
      pop_chk("reg_stream", sum_q);
    end

    rst = 1'b1;
    num1 = 4'h9;
    num2 = 4'h9;
    @(posedge clk); #1;
    chk("rst_mid", sum_q, 5'b00000);

    rst = 1'b0;
    drive(4'h9, 4'h9);
    @(posedge clk); #1;
    pop_chk("rst_release", sum_q);

    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_again", sum_q, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
